// File: rtl/nx_mesh_ctrl.sv
// nx_mesh_ctrl: run controller for the node mesh.
// Sequences mesh cycles (trigger, settle, wait for idle), circulates one token
// per column, counts completed cycles and drains all tokens home before ending.
// Optional feature macro: NX_MESH_CTRL_TIMEOUT_EN (WAIT_IDLE timeout of TIMEOUT cycles).
module nx_mesh_ctrl #(
    parameter int COLUMNS     = 3,
    parameter int CYCLE_WIDTH = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [CYCLE_WIDTH-1:0] cycles_i,
    input  logic                   mesh_idle_i,
    output logic                   mesh_trigger_o,
    output logic [COLUMNS-1:0]     token_grant_o,
    input  logic [COLUMNS-1:0]     token_release_i,
    output logic                   active_o,
    output logic                   done_o,
    output logic [CYCLE_WIDTH-1:0] cycle_count_o,
    output logic                   error_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIGGER   = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [COLUMNS-1:0]     r_held;
    logic [COLUMNS-1:0]     w_held_next;
    logic [COLUMNS-1:0]     r_grant;
    logic [COLUMNS-1:0]     w_grant_next;
    logic [CYCLE_WIDTH-1:0] r_target;
    logic [CYCLE_WIDTH-1:0] w_target_next;
    logic [CYCLE_WIDTH-1:0] r_count;
    logic [CYCLE_WIDTH-1:0] w_count_next;
    logic [CYCLE_WIDTH-1:0] w_count_inc;
    logic                   r_stop_pending;
    logic                   w_stop_pending_next;
    logic                   r_error;
    logic                   w_error_next;
    logic                   r_trigger;
    logic                   r_active;
    logic                   r_done;
    logic                   w_start_acc;
    logic                   w_run_phase;
    logic                   w_run_phase_next;
    logic                   w_spurious;
    logic                   w_all_home;
    logic                   w_target_hit;
    logic                   w_timeout;

    // Token engine and cycle sequencing only run while a mesh cycle is in flight.
    assign w_run_phase      = (r_state == ST_TRIGGER) || (r_state == ST_SETTLE) ||
                              (r_state == ST_WAIT_IDLE);
    assign w_run_phase_next = (w_state_next == ST_TRIGGER) || (w_state_next == ST_SETTLE) ||
                              (w_state_next == ST_WAIT_IDLE);
    assign w_all_home       = &r_held;
    assign w_spurious       = |(token_release_i & r_held);
    assign w_count_inc      = r_count + CYCLE_WIDTH'(1);
    assign w_target_hit     = (r_target != {CYCLE_WIDTH{1'b0}}) && (w_count_inc == r_target);

`ifdef NX_MESH_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] r_wait_cnt;

    // Count consecutive WAIT_IDLE cycles; any other state clears it so each entry starts at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= {TO_W{1'b0}};
        end else if (r_state == ST_WAIT_IDLE) begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
        end else begin
            r_wait_cnt <= {TO_W{1'b0}};
        end
    end

    assign w_timeout = (r_state == ST_WAIT_IDLE) && !mesh_idle_i &&
                       (r_wait_cnt == TO_W'(TIMEOUT - 1));
`else
    // Feature disabled: WAIT_IDLE never times out; TIMEOUT has no effect here.
    assign w_timeout = (TIMEOUT < 32'sd0);
`endif

    // Next-state logic for the run sequencer, including target/count bookkeeping.
    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_count_next  = r_count;
        w_start_acc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start_acc   = 1'b1;
                    w_target_next = cycles_i;
                    w_count_next  = {CYCLE_WIDTH{1'b0}};
                    w_state_next  = ST_TRIGGER;
                end else begin
                    w_state_next  = ST_IDLE;
                end
            end
            ST_TRIGGER: begin
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Node idle flags only drop one cycle after the trigger, so ignore them here.
                w_state_next = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (mesh_idle_i) begin
                    w_count_next = w_count_inc;
                    if (r_stop_pending || stop_i || w_target_hit) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_state_next = ST_TRIGGER;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_WAIT_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_all_home) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Token bookkeeping: a grant sends the token out, a release brings it home.
    // A release on a token already home is ignored here and flagged as an error.
    always_comb begin
        w_held_next  = (r_held & ~r_grant) | (token_release_i & ~r_held);
        if (w_run_phase_next) begin
            w_grant_next = w_held_next;
        end else begin
            w_grant_next = {COLUMNS{1'b0}};
        end
    end

    // Stop requests are remembered until the current mesh cycle completes; error is sticky per run.
    always_comb begin
        if (w_start_acc) begin
            w_stop_pending_next = 1'b0;
        end else if (w_run_phase && stop_i) begin
            w_stop_pending_next = 1'b1;
        end else begin
            w_stop_pending_next = r_stop_pending;
        end
        if (w_start_acc) begin
            w_error_next = w_spurious;
        end else begin
            w_error_next = r_error | w_spurious | w_timeout;
        end
    end

    // Sequencer state and run bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_held         <= {COLUMNS{1'b1}};
            r_target       <= {CYCLE_WIDTH{1'b0}};
            r_count        <= {CYCLE_WIDTH{1'b0}};
            r_stop_pending <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_held         <= w_held_next;
            r_target       <= w_target_next;
            r_count        <= w_count_next;
            r_stop_pending <= w_stop_pending_next;
            r_error        <= w_error_next;
        end
    end

    // Output registers, loaded from next-state values so each pulse lines up with its state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_trigger <= 1'b0;
            r_grant   <= {COLUMNS{1'b0}};
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_trigger <= (w_state_next == ST_TRIGGER);
            r_grant   <= w_grant_next;
            r_active  <= (w_state_next != ST_IDLE);
            r_done    <= (w_state_next == ST_DRAIN) && (&w_held_next);
        end
    end

    assign mesh_trigger_o = r_trigger;
    assign token_grant_o  = r_grant;
    assign active_o       = r_active;
    assign done_o         = r_done;
    assign cycle_count_o  = r_count;
    assign error_o        = r_error;

endmodule
